// File: rtl/mon_pkg.sv
// rtl/mon_pkg.sv - shared constants and helpers for the Endeavour monitor register bank
package mon_pkg;

    localparam int MON_ADDR_W = 8;

    localparam logic [MON_ADDR_W-1:0] MON_ADDR_CFG    = 8'h00;
    localparam logic [MON_ADDR_W-1:0] MON_ADDR_STATUS = 8'h10;
    localparam logic [MON_ADDR_W-1:0] MON_ADDR_TRIM   = 8'h20;
    localparam logic [MON_ADDR_W-1:0] MON_ADDR_MASK   = 8'h30;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/mon_vote3.sv
// rtl/mon_vote3.sv - per-bit 2-of-3 majority voter with per-bit disagreement flags
module mon_vote3 #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    output logic [WIDTH-1:0] voted,
    output logic [WIDTH-1:0] mismatch
);

    assign voted    = (a & b) | (a & c) | (b & c);
    assign mismatch = (a ^ b) | (a ^ c) | (b ^ c);

endmodule

// File: rtl/mon_regnt_scrub.sv
// rtl/mon_regnt_scrub.sv - TMR register with scrubbing, soft-error counter and serial readback
module mon_regnt_scrub
    import mon_pkg::*;
#(
    parameter int                    WIDTH       = 32,
    parameter logic [WIDTH-1:0]      RESET_VALUE = {WIDTH{1'b0}},
    parameter logic [MON_ADDR_W-1:0] REG_ADDR    = 8'h00,
    parameter int                    CNT_W       = 8
) (
    input  logic                  bclk,
    input  logic                  rstb,
    input  logic [WIDTH-1:0]      dataIn,
    input  logic [MON_ADDR_W-1:0] addrIn,
    input  logic                  latchIn,
    input  logic                  latchOut,
    input  logic                  shiftEn,
    input  logic                  clrErr,
    output logic [WIDTH-1:0]      dataOut,
    output logic                  serOut,
    output logic                  serSticky,
    output logic [CNT_W-1:0]      serCount,
    output logic                  shiftOut,
    output logic                  shiftBusy
);

    localparam int                BCNT_W    = clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [BCNT_W-1:0] BCNT_LOAD = BCNT_W'(WIDTH);

    logic [WIDTH-1:0]  a_q, b_q, c_q, copy_d;
    logic [WIDTH-1:0]  voted, mismatch;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              sticky_q, sticky_d;
    logic [WIDTH-1:0]  shift_q, shift_d;
    logic [BCNT_W-1:0] bitcnt_q, bitcnt_d;
    logic              sel, err;

    mon_vote3 #(.WIDTH(WIDTH)) u_vote (
        .a        (a_q),
        .b        (b_q),
        .c        (c_q),
        .voted    (voted),
        .mismatch (mismatch)
    );

    assign sel = (addrIn == REG_ADDR);
    assign err = |mismatch;

    always_comb begin
        // All three copies reload every cycle: either the write data or the voted value (scrub).
        copy_d = voted;
        if (latchIn && sel) copy_d = dataIn;

        cnt_d    = cnt_q;
        sticky_d = sticky_q;
        if (clrErr && sel) begin
            cnt_d    = '0;
            sticky_d = 1'b0;
        end else if (err) begin
            sticky_d = 1'b1;
            if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
        end

        // Readback loads the pre-write vote so a simultaneous write is not seen.
        shift_d  = shift_q;
        bitcnt_d = bitcnt_q;
        if (latchOut && sel) begin
            shift_d  = voted;
            bitcnt_d = BCNT_LOAD;
        end else if (shiftEn && (bitcnt_q != '0)) begin
            shift_d  = shift_q << 1;
            bitcnt_d = bitcnt_q - 1'b1;
        end
    end

    always_ff @(posedge bclk) begin
        if (!rstb) begin
            a_q      <= RESET_VALUE;
            b_q      <= RESET_VALUE;
            c_q      <= RESET_VALUE;
            cnt_q    <= '0;
            sticky_q <= 1'b0;
            shift_q  <= '0;
            bitcnt_q <= '0;
        end else begin
            a_q      <= copy_d;
            b_q      <= copy_d;
            c_q      <= copy_d;
            cnt_q    <= cnt_d;
            sticky_q <= sticky_d;
            shift_q  <= shift_d;
            bitcnt_q <= bitcnt_d;
        end
    end

    assign dataOut   = voted;
    assign serOut    = err;
    assign serSticky = sticky_q;
    assign serCount  = cnt_q;
    assign shiftOut  = shift_q[WIDTH-1];
    assign shiftBusy = (bitcnt_q != '0);

endmodule
